// File: rtl/pmp_csr_write_guard.sv
// PMP CSR write guard: WARL legalisation and lock masking of pmpcfg/pmpaddr
// writes ahead of the CSR file, behind a one-entry valid/ready output stage.
// Optional feature macro: PMP_BLOCKED_CNT_EN (saturating blocked-write counter).
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module pmp_csr_write_guard #(
  parameter int unsigned XLEN         = `XLEN_64b,
  parameter int unsigned PMP_ENTRIES  = 16,
  parameter logic [11:0] PMPCFG_BASE  = 12'h3A0,
  parameter logic [11:0] PMPADDR_BASE = 12'h3B0,
  localparam int unsigned W           = 1 << (XLEN + 4)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [11:0]            i_csr_addr,
  input  logic [W-1:0]           i_new_csr,
  input  logic [W-1:0]           i_old_csr,
  output logic                   o_wr_valid,
  input  logic                   i_wr_ready,
  output logic [11:0]            o_wr_addr,
  output logic [W-1:0]           o_wr_data,
  output logic                   o_wr_blocked,
  output logic                   o_wr_illegal,
  output logic [PMP_ENTRIES-1:0] o_lock_vec,
  output logic [15:0]            o_blocked_cnt
);

  localparam int unsigned NB    = W / 8;
  localparam bit          IS64  = (W == 64);
  localparam int unsigned EW    = $clog2(PMP_ENTRIES);
  localparam logic [6:0]  N7    = 7'(PMP_ENTRIES);
  localparam logic [1:0]  A_TOR = 2'b01;

  logic [PMP_ENTRIES-1:0]      r_lock;
  logic [PMP_ENTRIES-1:0][1:0] r_amode;
  logic                        r_valid;
  logic [11:0]                 r_addr;
  logic [W-1:0]                r_data;
  logic                        r_blocked;
  logic                        r_illegal;

  logic                        w_accept;
  logic [11:0]                 w_cfg_off;
  logic [11:0]                 w_addr_off;
  logic                        w_is_cfg;
  logic                        w_is_addr;
  logic [W-1:0]                w_data;
  logic                        w_blocked;
  logic                        w_illegal;
  logic                        w_cfg_commit;
  logic                        w_any_in;
  logic                        w_all_locked;
  logic [PMP_ENTRIES-1:0]      w_lock_nxt;
  logic [PMP_ENTRIES-1:0][1:0] w_amode_nxt;

  assign o_wr_ready = !r_valid | i_wr_ready;
  assign w_accept   = i_wr_valid & o_wr_ready;

  // Unsigned wrap-around makes addresses below the base fall out of range.
  assign w_cfg_off  = i_csr_addr - PMPCFG_BASE;
  assign w_addr_off = i_csr_addr - PMPADDR_BASE;
  assign w_is_cfg   = (w_cfg_off < 12'd16);
  assign w_is_addr  = (w_addr_off < 12'd64);

  always_comb begin : filter
    logic [6:0] v_entry;
    logic [7:0] v_byte;
    logic [5:0] v_idx;
    logic [6:0] v_next;
    // NOTE: every combinational output is defaulted first so no path infers a latch.
    w_data       = i_new_csr;
    w_blocked    = 1'b0;
    w_illegal    = 1'b0;
    w_cfg_commit = 1'b0;
    w_any_in     = 1'b0;
    w_all_locked = 1'b1;
    w_lock_nxt   = r_lock;
    w_amode_nxt  = r_amode;
    v_entry      = '0;
    v_byte       = '0;
    v_idx        = '0;
    v_next       = '0;

    if (w_is_cfg) begin
      if (IS64 && w_cfg_off[0]) begin
        w_data    = i_old_csr;
        w_illegal = 1'b1;
      end else begin
        w_cfg_commit = 1'b1;
        for (int j = 0; j < NB; j++) begin
          v_entry = {1'b0, w_cfg_off[3:0], 2'b00} + 7'(j);
          v_byte  = i_new_csr[8*j +: 8];
          if (v_entry < N7 && r_lock[v_entry[EW-1:0]]) begin
            v_byte   = i_old_csr[8*j +: 8];
            w_any_in = 1'b1;
          end else if (v_entry >= N7) begin
            v_byte = 8'h00;
          end else begin
            w_any_in     = 1'b1;
            w_all_locked = 1'b0;
            v_byte[6:5]  = 2'b00;
            // R=0,W=1 is reserved; legalise to no access.
            if (!v_byte[0] && v_byte[1]) v_byte[1] = 1'b0;
            w_lock_nxt[v_entry[EW-1:0]]  = v_byte[7];
            w_amode_nxt[v_entry[EW-1:0]] = v_byte[4:3];
          end
          w_data[8*j +: 8] = v_byte;
        end
        // A register covering no implemented entry has nothing locked.
        w_blocked = w_any_in & w_all_locked;
      end
    end else if (w_is_addr) begin
      v_idx  = w_addr_off[5:0];
      v_next = {1'b0, v_idx} + 7'd1;
      if ({1'b0, v_idx} >= N7) begin
        w_data = '0;
      end else if (r_lock[v_idx[EW-1:0]] ||
                   (v_next < N7 && r_lock[v_next[EW-1:0]] &&
                    r_amode[v_next[EW-1:0]] == A_TOR)) begin
        w_data    = i_old_csr;
        w_blocked = 1'b1;
      end else if (IS64) begin
        w_data[W-1 -: 10] = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the lock/A arrays are real state and are reset explicitly; nothing else clears a lock.
      r_lock    <= '0;
      r_amode   <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_blocked <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop update independent of statement order.
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_addr    <= i_csr_addr;
        r_data    <= w_data;
        r_blocked <= w_blocked;
        r_illegal <= w_illegal;
      end else if (i_wr_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept && w_cfg_commit) begin
        r_lock  <= w_lock_nxt;
        r_amode <= w_amode_nxt;
      end
    end
  end

  assign o_wr_valid   = r_valid;
  assign o_wr_addr    = r_addr;
  assign o_wr_data    = r_data;
  assign o_wr_blocked = r_blocked;
  assign o_wr_illegal = r_illegal;
  assign o_lock_vec   = r_lock;

`ifdef PMP_BLOCKED_CNT_EN
  logic [15:0] r_blocked_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blocked_cnt <= '0;
    end else if (w_accept && w_blocked && r_blocked_cnt != 16'hFFFF) begin
      r_blocked_cnt <= r_blocked_cnt + 16'd1;
    end
  end

  assign o_blocked_cnt = r_blocked_cnt;
`else
  assign o_blocked_cnt = '0;
`endif

endmodule

// File: tb/tb_pmp_csr_write_guard.sv
// Bench for pmp_csr_write_guard: an RV32 and an RV64 instance share one
// stimulus stream and are each checked against a behavioural PMP model.
module tb_pmp_csr_write_guard;

  localparam int N = 16;
`ifdef PMP_BLOCKED_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready = 1'b1;
  logic [11:0] csr_addr = '0;
  logic [63:0] new_csr = '0;
  logic [63:0] old_csr = '0;

  logic         rdy32, val32, blk32, ill32;
  logic [11:0]  addr32;
  logic [31:0]  data32;
  logic [N-1:0] lock32;
  logic [15:0]  cnt32;
  logic         rdy64, val64, blk64, ill64;
  logic [11:0]  addr64;
  logic [63:0]  data64;
  logic [N-1:0] lock64;
  logic [15:0]  cnt64;

  always #5 clk = ~clk;

  pmp_csr_write_guard #(.XLEN(1), .PMP_ENTRIES(N)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(rdy32),
    .i_csr_addr(csr_addr), .i_new_csr(new_csr[31:0]), .i_old_csr(old_csr[31:0]),
    .o_wr_valid(val32), .i_wr_ready(wr_ready), .o_wr_addr(addr32), .o_wr_data(data32),
    .o_wr_blocked(blk32), .o_wr_illegal(ill32), .o_lock_vec(lock32), .o_blocked_cnt(cnt32)
  );

  pmp_csr_write_guard #(.XLEN(2), .PMP_ENTRIES(N)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(rdy64),
    .i_csr_addr(csr_addr), .i_new_csr(new_csr), .i_old_csr(old_csr),
    .o_wr_valid(val64), .i_wr_ready(wr_ready), .o_wr_addr(addr64), .o_wr_data(data64),
    .o_wr_blocked(blk64), .o_wr_illegal(ill64), .o_lock_vec(lock64), .o_blocked_cnt(cnt64)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state; index 0 is the RV32 instance, 1 the RV64 instance.
  bit          m_lock[2][N];
  bit [1:0]    m_amode[2][N];
  bit          exp_valid;
  logic [11:0] exp_addr[2];
  logic [63:0] exp_data[2];
  bit          exp_blk[2];
  bit          exp_ill[2];
  int          exp_cnt[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_write(input int m, input logic [11:0] a, input logic [63:0] nw,
                             input logic [63:0] old, output logic [63:0] d,
                             output bit blk, output bit ill);
    int nb, k, e, i, in_range, locked;
    logic [63:0] nwm, oldm;
    logic [7:0] b;
    nb   = (m == 1) ? 8 : 4;
    nwm  = (m == 1) ? nw : {32'b0, nw[31:0]};
    oldm = (m == 1) ? old : {32'b0, old[31:0]};
    d = nwm; blk = 0; ill = 0;
    if (a >= 12'h3A0 && a <= 12'h3AF) begin
      k = int'(a) - 'h3A0;
      if (m == 1 && (k % 2) == 1) begin
        d = oldm; ill = 1;
      end else begin
        in_range = 0; locked = 0;
        for (int j = 0; j < nb; j++) begin
          e = 4 * k + j;
          b = nwm[8*j +: 8];
          if (e < N && m_lock[m][e]) begin
            b = oldm[8*j +: 8]; in_range++; locked++;
          end else if (e >= N) begin
            b = 8'h00;
          end else begin
            in_range++;
            b[6:5] = 2'b00;
            if (b[1:0] == 2'b10) b[1] = 1'b0;
            m_lock[m][e]  = b[7];
            m_amode[m][e] = b[4:3];
          end
          d[8*j +: 8] = b;
        end
        blk = (in_range > 0) && (locked == in_range);
      end
    end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
      i = int'(a) - 'h3B0;
      if (i >= N) d = '0;
      else if (m_lock[m][i] || (i + 1 < N && m_lock[m][i+1] && m_amode[m][i+1] == 2'b01)) begin
        d = oldm; blk = 1;
      end else if (m == 1) d[63:54] = '0;
    end
  endtask

  task automatic compare_outputs(input string ph);
    logic [N-1:0] lv0, lv1;
    for (int e = 0; e < N; e++) begin
      lv0[e] = m_lock[0][e];
      lv1[e] = m_lock[1][e];
    end
    check({ph, ".valid32"}, val32, exp_valid);
    check({ph, ".valid64"}, val64, exp_valid);
    if (exp_valid) begin
      check({ph, ".addr32"}, addr32, exp_addr[0]);
      check({ph, ".data32"}, data32, exp_data[0]);
      check({ph, ".blk32"}, blk32, exp_blk[0]);
      check({ph, ".ill32"}, ill32, exp_ill[0]);
      check({ph, ".addr64"}, addr64, exp_addr[1]);
      check({ph, ".data64"}, data64, exp_data[1]);
      check({ph, ".blk64"}, blk64, exp_blk[1]);
      check({ph, ".ill64"}, ill64, exp_ill[1]);
    end
    check({ph, ".lock32"}, lock32, lv0);
    check({ph, ".lock64"}, lock64, lv1);
    check({ph, ".cnt32"}, cnt32, CNT_EN ? exp_cnt[0] : 0);
    check({ph, ".cnt64"}, cnt64, CNT_EN ? exp_cnt[1] : 0);
  endtask

  // One clock: drive request, predict at the negedge, check #1 after posedge.
  task automatic step(input string ph, input bit v, input logic [11:0] a,
                      input logic [63:0] nw, input logic [63:0] old, input bit rdy);
    logic [63:0] d;
    bit b, il;
    wr_valid = v; csr_addr = a; new_csr = nw; old_csr = old; wr_ready = rdy;
    @(negedge clk);
    check({ph, ".ready32"}, rdy32, !exp_valid || rdy);
    check({ph, ".ready64"}, rdy64, !exp_valid || rdy);
    if (v && (!exp_valid || rdy)) begin
      for (int m = 0; m < 2; m++) begin
        model_write(m, a, nw, old, d, b, il);
        exp_data[m] = d; exp_blk[m] = b; exp_ill[m] = il; exp_addr[m] = a;
        if (b && exp_cnt[m] < 'hFFFF) exp_cnt[m]++;
      end
      exp_valid = 1;
    end else if (rdy) begin
      exp_valid = 0;
    end
    @(posedge clk);
    #1;
    compare_outputs(ph);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      for (int e = 0; e < N; e++) begin m_lock[m][e] = 0; m_amode[m][e] = 0; end
      exp_cnt[m] = 0;
    end
    exp_valid = 0;
    check("rst.valid32", val32, 0);
    check("rst.valid64", val64, 0);
    check("rst.lock32", lock32, 0);
    @(negedge clk);
    wr_valid = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.addr32", addr32, 0);
    check("rst.data32", data32, 0);
    check("rst.data64", data64, 0);
    check("rst.blk32", blk32, 0);
    check("rst.ill64", ill64, 0);
    compare_outputs("rst");
  endtask

  initial begin
    logic [11:0] a;
    logic [63:0] nw;
    apply_reset();

    // Lock entry 0, then pmpaddr0 is blocked; three blocked writes + one unblocked.
    step("tp1.cfg", 1, 12'h3A0, 64'h80, 64'h0, 1);
    check("tp1.cfg_data32", data32, 32'h80);
    step("tp1.addr", 1, 12'h3B0, 64'h1234, 64'h5555, 1);
    check("tp1.addr_data32", data32, 32'h5555);
    check("tp1.addr_blk32", blk32, 1);
    check("tp1.lock0", lock32[0], 1);
    step("tp1.addr2", 1, 12'h3B0, 64'h99, 64'h5555, 1);
    step("tp1.addr3", 1, 12'h3B0, 64'h77, 64'h5555, 1);
    check("tp1.cnt32", cnt32, CNT_EN ? 3 : 0);

    // Entry 1 locked with TOR locks pmpaddr0; pmpaddr2 passes.
    apply_reset();
    step("tp2.cfg", 1, 12'h3A0, 64'h8800, 64'h0, 1);
    step("tp2.addr0", 1, 12'h3B0, 64'hAAAA, 64'h1111, 1);
    check("tp2.addr0_blk32", blk32, 1);
    step("tp2.addr2", 1, 12'h3B2, 64'hBBBB, 64'h2222, 1);
    check("tp2.addr2_data32", data32, 32'hBBBB);

    // Odd pmpcfg index on RV64 is illegal; W-only byte legalises to 0.
    step("tp3.odd", 1, 12'h3A1, 64'h8080_8080_8080_8080, 64'hCAFE, 1);
    check("tp3.ill64", ill64, 1);
    check("tp3.data64", data64, 64'hCAFE);
    step("tp3.wonly", 1, 12'h3A0, 64'h02, 64'h8800, 1);
    check("tp3.wonly_data32", data32, 32'h8800);

    // Back-pressure for three cycles, then drain and accept together.
    step("tp4.load", 1, 12'h300, 64'h1111_2222_3333_4444, 64'h0, 1);
    for (int c = 0; c < 3; c++) begin
      step("tp4.stall", 1, 12'h301, 64'hDEAD, 64'h0, 0);
      check("tp4.stall_ready", rdy32, 0);
      check("tp4.stall_data64", data64, 64'h1111_2222_3333_4444);
    end
    step("tp4.b2b", 1, 12'h301, 64'hDEAD, 64'h0, 1);
    check("tp4.b2b_data32", data32, 32'hDEAD);
    step("tp4.drain", 0, 12'h0, 64'h0, 64'h0, 1);

    // Reset while an entry is pending clears locks and drops the entry.
    step("tp5.cfg", 1, 12'h3A0, 64'h80, 64'h0, 1);
    step("tp5.hold", 0, 12'h0, 64'h0, 64'h0, 0);
    apply_reset();
    step("tp5.addr", 1, 12'h3B0, 64'h4321, 64'h1, 1);
    check("tp5.data32", data32, 32'h4321);
    check("tp5.blk32", blk32, 0);

    // Random traffic over cfg, addr, neighbouring and unrelated CSRs.
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 149) apply_reset();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 12'h3A0 + 12'($urandom_range(0, 15));
        4, 5, 6, 7: a = 12'h3B0 + 12'($urandom_range(0, 63));
        8:          a = 12'($urandom_range(0, 4095));
        default:    a = ($urandom_range(0, 1) == 1) ? 12'h39F : 12'h3F0;
      endcase
      nw = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) nw = nw & 64'h7F7F_7F7F_7F7F_7F7F;
      step("rand", $urandom_range(0, 3) != 0, a, nw, {$urandom, $urandom},
           $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
